// File: rtl/bq_resp_frame_rx_pkg.sv
// bq_resp_frame_rx_pkg: shared state/status encodings and CRC constants for the response-frame parser
package bq_resp_frame_rx_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_DATA, ST_CRC, ST_FLUSH} state_t;
  typedef enum logic [2:0] {
    STS_OK   = 3'd0,
    STS_CRC  = 3'd1,
    STS_LINE = 3'd2,
    STS_TMO  = 3'd3,
    STS_INIT = 3'd4
  } status_t;
  localparam logic [15:0] CRC_POLY = 16'hA001;
  localparam logic [15:0] CRC_SEED = 16'hFFFF;
  localparam int MAX_LEN = 128;
endpackage

// File: rtl/bq_resp_frame_rx_crc16_byte.sv
// crc16_byte: combinational one-byte update of reflected CRC-16/IBM
module crc16_byte
  import bq_resp_frame_rx_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);
  always_comb begin
    crc_next = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) crc_next = crc_next[0] ? (crc_next >> 1) ^ CRC_POLY : crc_next >> 1;
  end
endmodule

// File: rtl/bq_resp_frame_rx.sv
// bq_resp_frame_rx: pops bq79606 response frames from the RX FIFO, streams the payload and reports a per-frame verdict
module bq_resp_frame_rx
  import bq_resp_frame_rx_pkg::*;
#(
  parameter int C_TIMEOUT_CYCLES = 100000,
  parameter int C_DATA_BITS      = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [C_DATA_BITS-1:0] RX_Data,
  input  logic                   RX_Data_Present,
  input  logic                   RX_Frame_Error,
  input  logic                   RX_Overrun_Error,
  output logic                   Read_RX_FIFO,
  output logic [7:0]             Out_Data,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic                   Out_Last,
  output logic [7:0]             Hdr_Len,
  output logic [7:0]             Hdr_Dev,
  output logic [15:0]            Hdr_Reg,
  output logic                   Frame_Done,
  output logic [2:0]             Frame_Status
);
  localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(MAX_LEN + 1);
  state_t state;
  logic pop, pop_q, line_err, tmo;
  logic [LW-1:0] idx;
  logic [TW-1:0] tmo_cnt;
  logic [15:0] crc, crc_in, crc_next;
  always_comb begin
    pop = !Reset && RX_Data_Present && !pop_q && (state != ST_DATA || !Out_Valid || Out_Ready);
    line_err = (state == ST_HDR || state == ST_DATA || state == ST_CRC) && (RX_Frame_Error || RX_Overrun_Error);
    tmo = state != ST_IDLE && !pop && tmo_cnt == TW'(C_TIMEOUT_CYCLES - 1);
    crc_in = state == ST_IDLE ? CRC_SEED : crc;
    Read_RX_FIFO = pop;
  end
  crc16_byte u_crc (.crc(crc_in), .data(RX_Data), .crc_next(crc_next));
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      pop_q <= 1'b0;
      idx <= '0;
      crc <= CRC_SEED;
      tmo_cnt <= '0;
      Out_Data <= '0;
      Out_Valid <= 1'b0;
      Out_Last <= 1'b0;
      Hdr_Len <= '0;
      Hdr_Dev <= '0;
      Hdr_Reg <= '0;
      Frame_Done <= 1'b0;
      Frame_Status <= STS_OK;
    end else begin
      pop_q <= pop;
      Frame_Done <= 1'b0;
      tmo_cnt <= (pop || line_err || state == ST_IDLE) ? '0 : tmo_cnt + 1'b1;
      if (pop) crc <= crc_next;
      if (Out_Valid && Out_Ready) begin
        Out_Valid <= 1'b0;
        Out_Last <= 1'b0;
      end
      // line errors outrank both the timeout and a coincident pop
      if (line_err) begin
        Frame_Done <= 1'b1;
        Frame_Status <= STS_LINE;
        state <= ST_FLUSH;
      end else if (tmo) begin
        Frame_Done <= state != ST_FLUSH;
        if (state != ST_FLUSH) Frame_Status <= STS_TMO;
        state <= ST_IDLE;
      end else if (pop) begin
        case (state)
          ST_IDLE: begin
            idx <= '0;
            if (RX_Data[7]) begin
              Frame_Done <= 1'b1;
              Frame_Status <= STS_INIT;
              state <= ST_FLUSH;
            end else begin
              Hdr_Len <= {1'b0, RX_Data[6:0]} + 8'd1;
              state <= ST_HDR;
            end
          end
          ST_HDR: begin
            idx <= idx == LW'(2) ? '0 : idx + 1'b1;
            if (idx == LW'(0)) Hdr_Dev <= RX_Data;
            if (idx == LW'(1)) Hdr_Reg[15:8] <= RX_Data;
            if (idx == LW'(2)) begin
              Hdr_Reg[7:0] <= RX_Data;
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            Out_Data <= RX_Data;
            Out_Valid <= 1'b1;
            Out_Last <= idx + 1'b1 == Hdr_Len;
            idx <= idx + 1'b1 == Hdr_Len ? '0 : idx + 1'b1;
            if (idx + 1'b1 == Hdr_Len) state <= ST_CRC;
          end
          ST_CRC: begin
            idx <= LW'(1);
            if (idx == LW'(1)) begin
              Frame_Done <= 1'b1;
              Frame_Status <= crc_next == 16'h0000 ? STS_OK : STS_CRC;
              state <= ST_IDLE;
            end
          end
          ST_FLUSH: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/bq_resp_frame_rx.md
# bq_resp_frame_rx

Receive-side frame parser placed directly after the UART-lite receiver's RX FIFO. It pops bytes from the FIFO and decodes bq79606 response frames: init byte, device address, 16-bit register address, 1–128 data bytes, then CRC16. Payload bytes are streamed downstream through a valid/ready port. At the end of each frame the block reports header fields and a CRC/error verdict.

## Interface
- C_TIMEOUT_CYCLES, 100000: inter-byte timeout in Clk cycles; also the idle gap that ends a flush.
- C_DATA_BITS, 8: RX FIFO word width; only 8 is supported.
- Clk  in  1  system clock
- Reset  in  1  reset Reset, synchronous, active-high; clock Clk
- RX_Data  in  8  FIFO head byte; valid whenever RX_Data_Present=1 (first-word-fall-through)
- RX_Data_Present  in  1  FIFO not empty
- RX_Frame_Error  in  1  receiver framing-error pulse
- RX_Overrun_Error  in  1  receiver overrun pulse
- Read_RX_FIFO  out  1  one-cycle pop strobe
- Out_Data  out  8  payload byte
- Out_Valid  out  1  Out_Data valid
- Out_Ready  in  1  downstream accepts the byte
- Out_Last  out  1  marks the last payload byte of the frame
- Hdr_Len  out  8  payload length, 1..128
- Hdr_Dev  out  8  device address
- Hdr_Reg  out  16  register address, big-endian on the wire
- Frame_Done  out  1  one-cycle status strobe
- Frame_Status  out  3  0 OK, 1 CRC fail, 2 line error, 3 timeout, 4 bad init byte

## Operation
- States:
  - IDLE: wait for a byte; it is the init byte.
  - HDR: device address, register address high byte, register address low byte.
  - DATA: Hdr_Len payload bytes.
  - CRC: CRC low byte, then CRC high byte.
  - FLUSH: discard bytes after an error.
- Init byte:
  - Bit7=1 (command frame) → pop it, Frame_Done with status 4, go to FLUSH.
  - Otherwise Hdr_Len = init[6:0]+1.
- CRC:
  - CRC-16/IBM reflected, polynomial 0xA001, seed 0xFFFF at init-byte pop.
  - Updated with every popped byte, including both CRC bytes.
  - Residual 0x0000 after the CRC high byte → status 0; otherwise status 1, then return to IDLE.
- Pop rule: Read_RX_FIFO=1 only when all of the following hold:
  - RX_Data_Present=1,
  - no pop in the previous cycle (at most one pop per 2 cycles),
  - in DATA: Out_Valid=0 or Out_Ready=1.
- Byte capture: each byte is sampled in its pop cycle.
- Payload output:
  - Out_Data/Out_Valid are registered from the pop cycle.
  - Out_Valid stays high until Out_Ready=1.
  - Out_Last=1 on the Hdr_Len-th byte.
  - The payload is streamed before the CRC verdict; the consumer discards it when status≠0.
- Line error: RX_Frame_Error or RX_Overrun_Error while in HDR/DATA/CRC → Frame_Done status 2, go to FLUSH. The same inputs are ignored in IDLE and FLUSH.
- Timeout:
  - Counter clears on every pop.
  - Reaching C_TIMEOUT_CYCLES in HDR/DATA/CRC → Frame_Done status 3, go to IDLE.
  - Reaching it in FLUSH → IDLE, with no strobe.
- FLUSH: pops and discards every byte, never drives Out_Valid.
- Abort mid-payload: an Out_Valid byte already presented is still held until accepted; Out_Last is not generated.

## Timing
- Reset values:
  - Read_RX_FIFO, Out_Valid, Out_Last, Frame_Done: 0.
  - Out_Data, Hdr_*: 0.
  - Frame_Status: 0.
  - State: IDLE; CRC: 0xFFFF; timeout counter: 0.
- Reset mid-frame: a partial frame is dropped silently; no Frame_Done.
- Header:
  - Hdr_Len is registered one cycle after the init pop.
  - Hdr_Dev/Hdr_Reg are registered one cycle after their pops.
  - All stay stable until the next init pop.
- Frame_Done/Frame_Status: asserted the cycle after the CRC high-byte pop, or the cycle after the error is detected. Frame_Status holds until the next Frame_Done.
- Boundary cases:
  - Hdr_Len=1: the first data byte carries Out_Last.
  - Init byte 0x7F: 128 data bytes.
  - Simultaneous timeout and pop: the pop wins and the counter clears.
  - Simultaneous line error and CRC high-byte pop: status 2.
- Throughput: a full 128-byte frame needs at least 2×134 cycles, well below UART byte time.

## Structure
- Shared package: state encoding, Frame_Status codes, CRC polynomial 0xA001 and seed 0xFFFF, max length 128.
- Sub-module crc16_byte: purely combinational 8-iteration reflected update, crc_next = f(crc, byte).
- Counters: timeout counter width $clog2(C_TIMEOUT_CYCLES+1); data byte counter 8 bits.

## Test plan
- Good frame:
  - Stimulus: init 0x02, dev 0x00, reg 0x0100, data 0x11 0x22 0x33, CRC appended LSB first by the bench model.
  - Response: three payload bytes with Out_Last on 0x33; Hdr_Len=3, Hdr_Dev=0x00, Hdr_Reg=0x0100; Frame_Status=0.
- Corrupt CRC:
  - Stimulus: same frame with the CRC low byte XOR 0x01.
  - Response: payload is still streamed; Frame_Status=1.
- crc16_byte unit check: ASCII "123456789" from seed 0xFFFF → 0x4B37.
- Backpressure: Out_Ready held low for 20 cycles mid-payload → no pops during the stall, no byte lost or duplicated, correct Out_Last.
- Errors:
  - Stimulus: RX_Frame_Error pulse after the 2nd data byte; then further bytes; then idle for C_TIMEOUT_CYCLES.
  - Response: Frame_Done with status 2; the further bytes are popped and discarded; the block returns to IDLE after the idle gap; the next good frame gives status 0.
- Timeout and bad init:
  - A 5-byte partial frame then silence → status 3 exactly C_TIMEOUT_CYCLES after the last pop.
  - Init 0x80 → status 4.
